// File: rtl/crossbar_range_mask_if.sv
// Command and mask-stream bundle for crossbar_range_mask.
// The slave modport is the mask generator's view; master is the driver's.
interface crossbar_range_mask_if #(
  parameter int NUM_COLS = 1024,
  parameter int IDX_W    = 10,
  parameter int LANES    = 32,
  parameter int NUM_CH   = 2
);
  localparam int NUM_WORDS = NUM_COLS / LANES;
  localparam int WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int HIT_W     = $clog2(NUM_COLS + 1);

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [NUM_CH*IDX_W-1:0]   cmd_start;
  logic [NUM_CH*IDX_W-1:0]   cmd_end;
  logic [NUM_CH-1:0]         cmd_ch_en;
  logic                      mask_valid;
  logic                      mask_ready;
  logic [LANES-1:0]          mask_data;
  logic [WIDX_W-1:0]         mask_idx;
  logic                      mask_last;
  logic [HIT_W-1:0]          hit_count;
  logic                      busy;

  modport master (
    output cmd_valid, cmd_start, cmd_end, cmd_ch_en, mask_ready,
    input  cmd_ready, mask_valid, mask_data, mask_idx, mask_last, hit_count, busy
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_end, cmd_ch_en, mask_ready,
    output cmd_ready, mask_valid, mask_data, mask_idx, mask_last, hit_count, busy
  );
endinterface

// File: rtl/crossbar_range_mask.sv
// Sweeps NUM_COLS crossbar columns LANES at a time, emitting the OR of up to NUM_CH
// column ranges as mask words with a running popcount. Optional macro: CROSSBAR_MASK_WRAP_EN.
module crossbar_range_mask #(
  parameter int NUM_COLS = 1024,
  parameter int IDX_W    = 10,
  parameter int LANES    = 32,
  parameter int NUM_CH   = 2
) (
  input logic                  clock,
  input logic                  reset_n,
  crossbar_range_mask_if.slave bus
);
  localparam int NUM_WORDS = NUM_COLS / LANES;
  localparam int WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int HIT_W     = $clog2(NUM_COLS + 1);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NUM_WORDS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Unsigned range test; an inverted range either wraps around the index space or is empty.
  function automatic logic in_range(input logic [IDX_W-1:0] col,
                                    input logic [IDX_W-1:0] lo,
                                    input logic [IDX_W-1:0] hi);
    logic hit;
    if (lo <= hi) begin
      hit = (col >= lo) && (col <= hi);
    end else begin
`ifdef CROSSBAR_MASK_WRAP_EN
      hit = (col >= lo) || (col <= hi);
`else
      hit = 1'b0;
`endif
    end
    return hit;
  endfunction

  function automatic logic [LANES-1:0] word_mask(input logic [WIDX_W-1:0]       widx,
                                                 input logic [NUM_CH*IDX_W-1:0] starts,
                                                 input logic [NUM_CH*IDX_W-1:0] ends,
                                                 input logic [NUM_CH-1:0]       en);
    logic [LANES-1:0] w;
    logic [IDX_W-1:0] col;
    w = '0;
    for (int lane = 0; lane < LANES; lane++) begin
      col = IDX_W'(int'(widx) * LANES + lane);
      for (int k = 0; k < NUM_CH; k++) begin
        if (en[k] && in_range(col, starts[k*IDX_W +: IDX_W], ends[k*IDX_W +: IDX_W])) begin
          w[lane] = 1'b1;
        end else begin
          w[lane] = w[lane];
        end
      end
    end
    return w;
  endfunction

  function automatic logic [HIT_W-1:0] popcount(input logic [LANES-1:0] w);
    logic [HIT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + HIT_W'(w[i]);
    end
    return cnt;
  endfunction

  state_t                  state_r;
  state_t                  state_n_s;
  logic [NUM_CH*IDX_W-1:0] start_r;
  logic [NUM_CH*IDX_W-1:0] end_r;
  logic [NUM_CH-1:0]       ch_en_r;
  logic [LANES-1:0]        mask_data_r;
  logic [WIDX_W-1:0]       mask_idx_r;
  logic                    mask_last_r;
  logic [HIT_W-1:0]        hit_count_r;

  logic                    cmd_fire_s;
  logic                    word_fire_s;
  logic [WIDX_W-1:0]       next_idx_s;
  logic [WIDX_W-1:0]       src_idx_s;
  logic [NUM_CH*IDX_W-1:0] src_start_s;
  logic [NUM_CH*IDX_W-1:0] src_end_s;
  logic [NUM_CH-1:0]       src_en_s;
  logic [LANES-1:0]        word_s;
  logic [HIT_W-1:0]        word_pop_s;

  assign cmd_fire_s  = bus.cmd_valid && (state_r == ST_IDLE);
  assign word_fire_s = bus.mask_ready && (state_r == ST_SWEEP);
  assign next_idx_s  = mask_idx_r + WIDX_W'(1);

  // Next-state decode for the IDLE/SWEEP controller.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_fire_s) begin
          state_n_s = ST_SWEEP;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (word_fire_s && mask_last_r) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_SWEEP;
        end
      end
      default: state_n_s = ST_IDLE;
    endcase
  end

  // Word-0 is built straight from the command inputs so it can be registered on the handshake edge.
  always_comb begin
    src_idx_s   = '0;
    src_start_s = bus.cmd_start;
    src_end_s   = bus.cmd_end;
    src_en_s    = bus.cmd_ch_en;
    if (state_r == ST_SWEEP) begin
      src_idx_s   = next_idx_s;
      src_start_s = start_r;
      src_end_s   = end_r;
      src_en_s    = ch_en_r;
    end else begin
      src_idx_s   = '0;
    end
    word_s     = word_mask(src_idx_s, src_start_s, src_end_s, src_en_s);
    word_pop_s = popcount(word_s);
  end

  // State, latched command and registered mask word/count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      start_r     <= '0;
      end_r       <= '0;
      ch_en_r     <= '0;
      mask_data_r <= '0;
      mask_idx_r  <= '0;
      mask_last_r <= 1'b0;
      hit_count_r <= '0;
    end else begin
      state_r <= state_n_s;
      if (cmd_fire_s) begin
        start_r     <= bus.cmd_start;
        end_r       <= bus.cmd_end;
        ch_en_r     <= bus.cmd_ch_en;
        mask_data_r <= word_s;
        mask_idx_r  <= '0;
        mask_last_r <= (NUM_WORDS == 1);
        hit_count_r <= word_pop_s;
      end else if (word_fire_s && !mask_last_r) begin
        mask_data_r <= word_s;
        mask_idx_r  <= next_idx_s;
        mask_last_r <= (next_idx_s == LAST_IDX);
        hit_count_r <= hit_count_r + word_pop_s;
      end else if (word_fire_s) begin
        // Final total stays readable in IDLE; the word fields are cleared.
        mask_data_r <= '0;
        mask_idx_r  <= '0;
        mask_last_r <= 1'b0;
      end else begin
        mask_data_r <= mask_data_r;
        mask_idx_r  <= mask_idx_r;
        mask_last_r <= mask_last_r;
        hit_count_r <= hit_count_r;
      end
    end
  end

  assign bus.cmd_ready  = (state_r == ST_IDLE);
  assign bus.mask_valid = (state_r == ST_SWEEP);
  assign bus.busy       = (state_r != ST_IDLE);
  assign bus.mask_data  = mask_data_r;
  assign bus.mask_idx   = mask_idx_r;
  assign bus.mask_last  = mask_last_r;
  assign bus.hit_count  = hit_count_r;

endmodule

// File: tb/tb_crossbar_range_mask.sv
// Self-checking bench for crossbar_range_mask: directed sweeps plus randomized ranges
// compared against a whole-column-space reference model.
module tb_crossbar_range_mask;
  localparam int NUM_COLS = 1024;
  localparam int IDX_W    = 10;
  localparam int LANES    = 32;
  localparam int NUM_CH   = 2;
  localparam int NW       = NUM_COLS / LANES;
  localparam int MAXC     = 400;
`ifdef CROSSBAR_MASK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [NUM_COLS-1:0] ref_cols;
  logic [LANES-1:0]    obs_words [NW];
  logic [10:0]         last_hit;

  crossbar_range_mask_if #(.NUM_COLS(NUM_COLS), .IDX_W(IDX_W), .LANES(LANES), .NUM_CH(NUM_CH)) bus ();

  crossbar_range_mask #(.NUM_COLS(NUM_COLS), .IDX_W(IDX_W), .LANES(LANES), .NUM_CH(NUM_CH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: set of selected columns over the whole index space.
  task automatic build_ref(input int s0, input int e0, input int s1, input int e1, input logic [1:0] en);
    int s [2];
    int e [2];
    s[0] = s0; e[0] = e0; s[1] = s1; e[1] = e1;
    ref_cols = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (en[k]) begin
          if (s[k] <= e[k]) begin
            if (c >= s[k] && c <= e[k]) ref_cols[c] = 1'b1;
          end else if (WRAP) begin
            if (c >= s[k] || c <= e[k]) ref_cols[c] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic int ref_hits_upto(input int w);
    int n = 0;
    for (int c = 0; c < (w + 1) * LANES; c++) n += int'(ref_cols[c]);
    return n;
  endfunction

  // mode: 0 = always ready, 1 = ready toggling (starts low), 2 = random ready.
  task automatic sweep(input int s0, input int e0, input int s1, input int e1, input logic [1:0] en,
                       input int mode, input bit pulse, input int abort_at);
    int  w;
    int  cyc;
    bit  done;
    logic rdy;
    build_ref(s0, e0, s1, e1, en);
    bus.cmd_start = {IDX_W'(s1), IDX_W'(s0)};
    bus.cmd_end   = {IDX_W'(e1), IDX_W'(e0)};
    bus.cmd_ch_en = en;
    bus.mask_ready = 1'b0;
    chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid = 1'b1;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    w = 0; cyc = 0; done = 1'b0;
    while (!done) begin
      if (cyc >= MAXC) begin
        checks++; errors++;
        $error("FAIL sweep_timeout observed=%0d words expected=%0d", w, NW);
        break;
      end
      chk("mask_valid", 64'(bus.mask_valid), 64'(1));
      if (bus.mask_valid !== 1'b1) break;
      chk($sformatf("mask_idx[%0d]", w), 64'(bus.mask_idx), 64'(w));
      chk($sformatf("mask_data[%0d]", w), 64'(bus.mask_data), 64'(ref_cols[w*LANES +: LANES]));
      chk($sformatf("mask_last[%0d]", w), 64'(bus.mask_last), 64'(w == NW - 1));
      chk($sformatf("hit_count[%0d]", w), 64'(bus.hit_count), 64'(ref_hits_upto(w)));
      chk("sweep_cmd_ready", 64'(bus.cmd_ready), 64'(0));
      chk("sweep_busy", 64'(bus.busy), 64'(1));
      obs_words[w] = bus.mask_data;
      last_hit = bus.hit_count;
      if (abort_at == w) begin
        reset_n = 1'b0;
        bus.mask_ready = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        bus.mask_ready = 1'b0;
        chk("abort_mask_valid", 64'(bus.mask_valid), 64'(0));
        chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("abort_hit_count", 64'(bus.hit_count), 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_mask_idx", 64'(bus.mask_idx), 64'(0));
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.mask_ready = rdy;
      if (pulse) begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_start = 20'($urandom);
        bus.cmd_ch_en = 2'b11;
      end
      @(posedge clock); #1;
      cyc++;
      if (rdy) begin
        if (w == NW - 1) done = 1'b1;
        w++;
      end
    end
    bus.cmd_valid  = 1'b0;
    bus.mask_ready = 1'b0;
    bus.cmd_start  = {IDX_W'(s1), IDX_W'(s0)};
    bus.cmd_ch_en  = en;
    chk("end_mask_valid", 64'(bus.mask_valid), 64'(0));
    chk("end_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("end_busy", 64'(bus.busy), 64'(0));
    if (mode == 0) chk("sweep_cycles", 64'(cyc), 64'(NW));
    if (mode == 1) chk("sweep_cycles", 64'(cyc), 64'(2 * NW));
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_start  = '0;
    bus.cmd_end    = '0;
    bus.cmd_ch_en  = '0;
    bus.mask_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("rst_mask_valid", 64'(bus.mask_valid), 64'(0));
    chk("rst_mask_data", 64'(bus.mask_data), 64'(0));
    chk("rst_mask_idx", 64'(bus.mask_idx), 64'(0));
    chk("rst_mask_last", 64'(bus.mask_last), 64'(0));
    chk("rst_hit_count", 64'(bus.hit_count), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Single range, ch1 disabled, full-rate drain.
    sweep(5, 40, 100, 200, 2'b01, 0, 1'b0, -1);
    chk("t1_word0", 64'(obs_words[0]), 64'h0000_0000_FFFF_FFE0);
    chk("t1_word1", 64'(obs_words[1]), 64'h0000_0000_0000_01FF);
    chk("t1_word2", 64'(obs_words[2]), 64'h0);
    chk("t1_hits", 64'(last_hit), 64'd36);

    // One-column ranges at both ends of the index space.
    sweep(0, 0, 1023, 1023, 2'b11, 0, 1'b0, -1);
    chk("t2_word0", 64'(obs_words[0]), 64'h0000_0000_0000_0001);
    chk("t2_word31", 64'(obs_words[31]), 64'h0000_0000_8000_0000);
    chk("t2_hits", 64'(last_hit), 64'd2);

    // Overlapping ranges counted once.
    sweep(10, 20, 15, 30, 2'b11, 0, 1'b0, -1);
    chk("t3_word0", 64'(obs_words[0]), 64'h0000_0000_7FFF_FC00);
    chk("t3_hits", 64'(last_hit), 64'd21);

    // Toggling backpressure with stray commands during the sweep.
    sweep(60, 500, 300, 900, 2'b11, 1, 1'b1, -1);

    // Inverted range.
    sweep(1000, 3, 0, 0, 2'b01, 0, 1'b0, -1);
    if (WRAP) begin
      chk("t5_word0", 64'(obs_words[0]), 64'h0000_0000_0000_000F);
      chk("t5_word31", 64'(obs_words[31]), 64'h0000_0000_FFFF_FF00);
      chk("t5_hits", 64'(last_hit), 64'd28);
    end else begin
      chk("t5_word0", 64'(obs_words[0]), 64'h0);
      chk("t5_word31", 64'(obs_words[31]), 64'h0);
      chk("t5_hits", 64'(last_hit), 64'd0);
    end

    // Reset mid-sweep, then a fresh sweep from word 0.
    sweep(100, 700, 0, 0, 2'b01, 0, 1'b0, 10);
    @(posedge clock); #1;
    sweep(33, 77, 500, 520, 2'b11, 0, 1'b0, -1);

    // Randomized ranges, enables, backpressure and stray commands.
    for (int n = 0; n < 16; n++) begin
      int s0, e0, s1, e1;
      s0 = int'($urandom_range(0, NUM_COLS - 1));
      s1 = int'($urandom_range(0, NUM_COLS - 1));
      e0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_COLS - 1))
                                       : ((s0 + int'($urandom_range(0, 80))) % NUM_COLS);
      e1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_COLS - 1))
                                       : ((s1 + int'($urandom_range(0, 80))) % NUM_COLS);
      sweep(s0, e0, s1, e1, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
